salamander_top_level: RTL and testbench

Top of the Salamander-4 accumulator core. It holds a 32-word instruction memory that a host loads through a simple write port. It fetches and executes one 6-bit instruction per clock against an 8-bit accumulator and a 4-entry register file. The block has no bus master; the host observes it through the status outputs and two internal nets.

---
 rtl/salamander_pkg.sv | 25 ++
 rtl/salamander_top_level_alu.sv | 27 ++
 rtl/salamander_top_level.sv | 74 +++++++
 tb/tb_salamander_top_level.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/salamander_pkg.sv
// Shared constants for the Salamander-4 accumulator core: opcodes, instruction
// field positions and register-file geometry.
package salamander_pkg;

  localparam int unsigned REG_COUNT = 4;
  localparam int unsigned REG_IDX_W = 2;

  localparam int unsigned F_REG_HI = 5;
  localparam int unsigned F_REG_LO = 4;
  localparam int unsigned F_OP_HI  = 3;
  localparam int unsigned F_OP_LO  = 1;
  localparam int unsigned F_E      = 0;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_LD  = 3'b001,
    OP_ST  = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_AND = 3'b101,
    OP_XOR = 3'b110,
    OP_INC = 3'b111
  } opcode_e;

endpackage

// File: rtl/salamander_top_level_alu.sv
// Combinational ALU for the Salamander-4 core; all arithmetic wraps at 2^SIZE.
module alu
  import salamander_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] r,
  input  opcode_e         opcode,
  output logic [SIZE-1:0] result
);

  // NOP and ST pass A through; the top level ignores the result for them.
  always_comb begin
    result = a;
    case (opcode)
      OP_LD:   result = r;
      OP_ADD:  result = a + r;
      OP_SUB:  result = a - r;
      OP_AND:  result = a & r;
      OP_XOR:  result = a ^ r;
      OP_INC:  result = a + SIZE'(1);
      default: result = a;
    endcase
  end

endmodule

// File: rtl/salamander_top_level.sv
// Salamander-4 top: instruction memory with host write port, PC, accumulator,
// four-entry register file and one-instruction-per-cycle execution.
module salamander_top_level
  import salamander_pkg::*;
#(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned DATA_SIZE = 6,
  parameter int unsigned ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 W,
  input  logic [DATA_SIZE-1:0] DATA_WR,
  input  logic [ADDR_SIZE-1:0] ADDR,
  output logic [SIZE-1:0]      acc_out,
  output logic [ADDR_SIZE-1:0] pc_out
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [SIZE-1:0]      regs [REG_COUNT];
  logic [SIZE-1:0]      acc;
  logic [ADDR_SIZE-1:0] pc;

  logic [DATA_SIZE-1:0] instr;
  logic [REG_IDX_W-1:0] r_idx;
  opcode_e              op;
  logic                 dest_acc;
  logic [SIZE-1:0]      alu_result;
  logic [SIZE-1:0]      ALU_out_val_w;
  logic [SIZE-1:0]      REG_FILE_DATA_OUT_w;

  // Combinational fetch and decode of the word at pc.
  assign instr               = mem[pc];
  assign r_idx               = instr[F_REG_HI:F_REG_LO];
  assign op                  = opcode_e'(instr[F_OP_HI:F_OP_LO]);
  assign dest_acc            = instr[F_E];
  assign REG_FILE_DATA_OUT_w = regs[r_idx];
  assign ALU_out_val_w       = acc;

  alu #(.SIZE(SIZE)) u_alu (
    .a      (acc),
    .r      (REG_FILE_DATA_OUT_w),
    .opcode (op),
    .result (alu_result)
  );

  // Reset beats host writes; a host write stalls execution for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      acc <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (W) begin
      mem[ADDR] <= DATA_WR;
    end else begin
      pc <= pc + ADDR_SIZE'(1);
      case (op)
        OP_NOP: ;
        OP_ST:  regs[r_idx] <= acc;
        default: begin
          if (dest_acc) acc <= alu_result;
          else          regs[r_idx] <= alu_result;
        end
      endcase
    end
  end

  assign acc_out = acc;
  assign pc_out  = pc;

endmodule

// File: tb/tb_salamander_top_level.sv
// Directed and randomized bench for salamander_top_level against an
// instruction-level reference model.
module tb_salamander_top_level;

  logic       clk;
  logic       rst;
  logic       W;
  logic [5:0] DATA_WR;
  logic [4:0] ADDR;
  logic [7:0] acc_out;
  logic [4:0] pc_out;

  int checks = 0;
  int errors = 0;

  // Reference machine state
  logic [5:0] m_mem [32];
  logic [7:0] m_reg [4];
  logic [7:0] m_acc;
  logic [4:0] m_pc;

  salamander_top_level dut (
    .clk     (clk),
    .rst     (rst),
    .W       (W),
    .DATA_WR (DATA_WR),
    .ADDR    (ADDR),
    .acc_out (acc_out),
    .pc_out  (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_step(input logic r, input logic w,
                                     input logic [5:0] d, input logic [4:0] a);
    logic [5:0] word;
    int ri, op;
    logic [7:0] rv, res;
    if (r) begin
      m_pc = 0; m_acc = 0;
      for (int i = 0; i < 4; i++) m_reg[i] = 0;
      for (int i = 0; i < 32; i++) m_mem[i] = 0;
    end else if (w) begin
      m_mem[a] = d;
    end else begin
      word = m_mem[m_pc];
      ri   = int'(word) / 16;
      op   = (int'(word) / 2) % 8;
      rv   = m_reg[ri];
      res  = 8'(0);
      case (op)
        1: res = rv;
        3: res = 8'((int'(m_acc) + int'(rv)) % 256);
        4: res = 8'((int'(m_acc) - int'(rv) + 256) % 256);
        5: res = m_acc & rv;
        6: res = m_acc ^ rv;
        7: res = 8'((int'(m_acc) + 1) % 256);
        default: res = 8'(0);
      endcase
      if (op == 2) m_reg[ri] = m_acc;
      else if (op != 0) begin
        if (word[0]) m_acc = res;
        else m_reg[ri] = res;
      end
      m_pc = 5'((int'(m_pc) + 1) % 32);
    end
  endfunction

  task automatic check_state(input string tag);
    logic [7:0] exp_rd;
    exp_rd = m_reg[int'(m_mem[m_pc]) / 16];
    checks++;
    assert (acc_out === m_acc) else begin
      errors++; $error("FAIL %s acc_out got %0h exp %0h", tag, acc_out, m_acc);
    end
    checks++;
    assert (pc_out === m_pc) else begin
      errors++; $error("FAIL %s pc_out got %0d exp %0d", tag, pc_out, m_pc);
    end
    checks++;
    assert (dut.ALU_out_val_w === m_acc) else begin
      errors++; $error("FAIL %s ALU_out_val_w got %0h exp %0h", tag, dut.ALU_out_val_w, m_acc);
    end
    checks++;
    assert (dut.REG_FILE_DATA_OUT_w === exp_rd) else begin
      errors++; $error("FAIL %s REG_FILE_DATA_OUT_w got %0h exp %0h", tag, dut.REG_FILE_DATA_OUT_w, exp_rd);
    end
  endtask

  task automatic cycle(input logic r, input logic w, input logic [5:0] d,
                       input logic [4:0] a, input string tag);
    rst = r; W = w; DATA_WR = d; ADDR = a;
    @(posedge clk);
    model_step(r, w, d, a);
    #1;
    check_state(tag);
  endtask

  task automatic expect_acc(input logic [7:0] exp, input string tag);
    checks++;
    assert (acc_out === exp) else begin
      errors++; $error("FAIL %s acc_out got %0h exp %0h", tag, acc_out, exp);
    end
  endtask

  task automatic expect_pc(input logic [4:0] exp, input string tag);
    checks++;
    assert (pc_out === exp) else begin
      errors++; $error("FAIL %s pc_out got %0d exp %0d", tag, pc_out, exp);
    end
  endtask

  task automatic expect_reg1(input logic [7:0] exp, input string tag);
    checks++;
    assert (dut.REG_FILE_DATA_OUT_w === exp) else begin
      errors++; $error("FAIL %s reg1 read got %0h exp %0h", tag, dut.REG_FILE_DATA_OUT_w, exp);
    end
  endtask

  task automatic load(input logic [5:0] d, input logic [4:0] a);
    cycle(1'b0, 1'b1, d, a, "load");
  endtask

  logic [7:0] held_acc;
  logic [4:0] held_pc;
  int         budget;

  initial begin
    rst = 1'b1; W = 1'b0; DATA_WR = '0; ADDR = '0;
    m_acc = 0; m_pc = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 0;

    // Reset then free-run NOPs
    cycle(1'b1, 1'b0, 6'h00, 5'd0, "reset");
    cycle(1'b1, 1'b0, 6'h00, 5'd0, "reset");
    expect_acc(8'h00, "reset_acc");
    expect_pc(5'd0, "reset_pc");
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 1'b0, 6'h00, 5'd0, "nop_run");
      expect_pc(5'(i), "nop_pc");
      expect_acc(8'h00, "nop_acc");
    end

    // Build and store a value
    cycle(1'b1, 1'b0, 6'h00, 5'd0, "reset");
    load(6'h0F, 5'd0); load(6'h0F, 5'd1); load(6'h14, 5'd2); load(6'h17, 5'd3);
    load(6'h10, 5'd4);
    cycle(1'b0, 1'b0, 6'h00, 5'd0, "build"); expect_acc(8'h01, "build_inc1");
    cycle(1'b0, 1'b0, 6'h00, 5'd0, "build"); expect_acc(8'h02, "build_inc2");
    cycle(1'b0, 1'b0, 6'h00, 5'd0, "build"); expect_reg1(8'h02, "build_st_r1");
    cycle(1'b0, 1'b0, 6'h00, 5'd0, "build"); expect_acc(8'h04, "build_add");

    // Subtract with wrap
    cycle(1'b1, 1'b0, 6'h00, 5'd0, "reset");
    load(6'h0F, 5'd0); load(6'h14, 5'd1); load(6'h1D, 5'd2); load(6'h19, 5'd3);
    load(6'h0F, 5'd4);
    cycle(1'b0, 1'b0, 6'h00, 5'd0, "sub"); expect_acc(8'h01, "sub_inc");
    cycle(1'b0, 1'b0, 6'h00, 5'd0, "sub"); expect_acc(8'h01, "sub_st");
    cycle(1'b0, 1'b0, 6'h00, 5'd0, "sub"); expect_acc(8'h00, "sub_xor");
    cycle(1'b0, 1'b0, 6'h00, 5'd0, "sub"); expect_acc(8'hFF, "sub_wrap");
    cycle(1'b0, 1'b0, 6'h00, 5'd0, "sub"); expect_acc(8'h00, "sub_inc_wrap");

    // Destination select: ADD r1 with E=0 writes reg1 only
    cycle(1'b1, 1'b0, 6'h00, 5'd0, "reset");
    load(6'h0F, 5'd0); load(6'h0F, 5'd1); load(6'h14, 5'd2); load(6'h16, 5'd3);
    load(6'h10, 5'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 6'h00, 5'd0, "dest");
    expect_acc(8'h02, "dest_acc_hold");
    expect_reg1(8'h04, "dest_reg1");

    // Write stall: pc and acc frozen for three cycles
    held_acc = acc_out; held_pc = pc_out;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 6'h0F, 5'd20, "stall");
      expect_acc(held_acc, "stall_acc");
      expect_pc(held_pc, "stall_pc");
    end
    cycle(1'b0, 1'b0, 6'h00, 5'd0, "resume");
    expect_pc(5'(held_pc + 5'd1), "resume_pc");

    // Randomized program with occasional host writes, runs past the wrap
    cycle(1'b1, 1'b0, 6'h00, 5'd0, "reset");
    for (int i = 0; i < 32; i++) load(6'($urandom), 5'(i));
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0)
        cycle(1'b0, 1'b1, 6'($urandom), ($urandom_range(0, 1) == 0) ? m_pc : 5'($urandom),
              "rand_write");
      else
        cycle(1'b0, 1'b0, 6'h00, 5'd0, "rand_exec");
    end

    // Mid-run reset at pc = 9 clears accumulator and program
    budget = 0;
    while (m_pc != 5'd9 && budget < 100) begin
      cycle(1'b0, 1'b0, 6'h00, 5'd0, "seek9");
      budget++;
    end
    checks++;
    assert (budget < 100) else begin
      errors++; $error("FAIL seek_pc9 budget got %0d exp <100", budget);
    end
    cycle(1'b1, 1'b0, 6'h00, 5'd0, "midreset");
    expect_acc(8'h00, "midreset_acc");
    expect_pc(5'd0, "midreset_pc");
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 6'h00, 5'd0, "post_reset");
    expect_acc(8'h00, "post_reset_acc");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
